inert_sched: RTL and testbench



---
 rtl/inert_pkg.sv | 54 +++++
 rtl/synch_2ff.sv | 29 ++
 rtl/inert_sched.sv | 157 +++++++++++++++
 tb/tb_inert_sched.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inert_pkg.sv
// Shared types and SPI command constants for the inertial sensor scheduler.
// Configuration words and read addresses are fixed by the sensor register map.
package inert_pkg;

  typedef enum logic [2:0] {
    ST_POR,
    ST_CFG_ISSUE,
    ST_CFG_WAIT,
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_PUBLISH
  } sched_state_t;

  localparam logic [15:0] CFG_INT_EN   = 16'h0D02;
  localparam logic [15:0] CFG_GYRO_ODR = 16'h1160;
  localparam logic [15:0] CFG_ROUNDING = 16'h1440;
  localparam logic [2:0]  CFG_LAST_IDX = 3'd2;

  localparam logic [7:0] READ_FLAG = 8'h80;

  localparam logic [7:0] RD_PTCH_L = 8'hA2;
  localparam logic [7:0] RD_PTCH_H = 8'hA3;
  localparam logic [7:0] RD_ROLL_L = 8'hA4;
  localparam logic [7:0] RD_ROLL_H = 8'hA5;
  localparam logic [7:0] RD_YAW_L  = 8'hA6;
  localparam logic [7:0] RD_YAW_H  = 8'hA7;
  localparam logic [2:0] RD_LAST_IDX = 3'd5;

  function automatic logic [15:0] cfg_cmd(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = CFG_INT_EN;
      3'd1:    c = CFG_GYRO_ODR;
      default: c = CFG_ROUNDING;
    endcase
    return c;
  endfunction

  // Low address byte of each rate comes first so the words assemble little-endian.
  function automatic logic [15:0] rd_cmd(input logic [2:0] idx);
    logic [7:0] addr;
    case (idx)
      3'd0:    addr = RD_PTCH_L;
      3'd1:    addr = RD_PTCH_H;
      3'd2:    addr = RD_ROLL_L;
      3'd3:    addr = RD_ROLL_H;
      3'd4:    addr = RD_YAW_L;
      default: addr = RD_YAW_H;
    endcase
    return {addr | READ_FLAG, 8'h00};
  endfunction

endpackage

// File: rtl/synch_2ff.sv
// Two-flop synchronizer for a slow asynchronous level; 2-cycle latency, no backpressure.
module synch_2ff (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/inert_sched.sv
// Configures the gyro over the shared SPI monarch, then reads six rate bytes per data-ready and publishes pitch/roll/yaw.
// Latency: done -> next wrt 2 cycles, last done -> vld 2 cycles; waits on done indefinitely, INT is never queued.
module inert_sched
  import inert_pkg::*;
#(
  parameter logic [15:0] POR_CYCLES = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        init_done,
  output logic [15:0] ptch_rt,
  output logic [15:0] roll_rt,
  output logic [15:0] yaw_rt,
  output logic        vld
);

  localparam logic [15:0] POR_LAST = POR_CYCLES - 16'd1;

  logic int_s;

  sched_state_t    state_q, state_d;
  logic [15:0]     por_cnt_q, por_cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0][7:0] buf_q, buf_d;
  logic            wrt_q, wrt_d;
  logic [15:0]     cmd_q, cmd_d;
  logic            init_done_q, init_done_d;
  logic            vld_q, vld_d;
  logic [15:0]     ptch_q, ptch_d;
  logic [15:0]     roll_q, roll_d;
  logic [15:0]     yaw_q, yaw_d;

  // The sensor answers with one byte; the upper half of the SPI word is don't-care.
  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_data[15:8];

  synch_2ff u_int_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (INT),
    .sync_out (int_s)
  );

  always_comb begin
    state_d     = state_q;
    por_cnt_d   = por_cnt_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    wrt_d       = 1'b0;
    cmd_d       = cmd_q;
    init_done_d = init_done_q;
    vld_d       = 1'b0;
    ptch_d      = ptch_q;
    roll_d      = roll_q;
    yaw_d       = yaw_q;

    unique case (state_q)
      ST_POR: begin
        if (por_cnt_q == POR_LAST) begin
          idx_d   = 3'd0;
          state_d = ST_CFG_ISSUE;
        end else begin
          por_cnt_d = por_cnt_q + 16'd1;
        end
      end
      ST_CFG_ISSUE: begin
        wrt_d   = 1'b1;
        cmd_d   = cfg_cmd(idx_q);
        state_d = ST_CFG_WAIT;
      end
      ST_CFG_WAIT: begin
        if (done) begin
          if (idx_q == CFG_LAST_IDX) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_CFG_ISSUE;
          end
        end
      end
      ST_IDLE: begin
        if (int_s) begin
          idx_d   = 3'd0;
          state_d = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        wrt_d   = 1'b1;
        cmd_d   = rd_cmd(idx_q);
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (done) begin
          buf_d[idx_q] = rd_data[7:0];
          if (idx_q == RD_LAST_IDX) begin
            state_d = ST_PUBLISH;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_RD_ISSUE;
          end
        end
      end
      ST_PUBLISH: begin
        // All three words move together so downstream never sees a mixed sample.
        ptch_d  = {buf_q[1], buf_q[0]};
        roll_d  = {buf_q[3], buf_q[2]};
        yaw_d   = {buf_q[5], buf_q[4]};
        vld_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_POR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_POR;
      por_cnt_q   <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
      wrt_q       <= 1'b0;
      cmd_q       <= '0;
      init_done_q <= 1'b0;
      vld_q       <= 1'b0;
      ptch_q      <= '0;
      roll_q      <= '0;
      yaw_q       <= '0;
    end else begin
      state_q     <= state_d;
      por_cnt_q   <= por_cnt_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      wrt_q       <= wrt_d;
      cmd_q       <= cmd_d;
      init_done_q <= init_done_d;
      vld_q       <= vld_d;
      ptch_q      <= ptch_d;
      roll_q      <= roll_d;
      yaw_q       <= yaw_d;
    end
  end

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign init_done = init_done_q;
  assign vld       = vld_q;
  assign ptch_rt   = ptch_q;
  assign roll_rt   = roll_q;
  assign yaw_rt    = yaw_q;

endmodule

// File: tb/tb_inert_sched.sv
// Bench for inert_sched: SPI responder model plus scoreboards for command words and published rate words.
module tb_inert_sched;

  localparam logic [15:0] POR = 16'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        int_in = 1'b0;
  logic        spi_done = 1'b0;
  logic        inj_done = 1'b0;
  logic [15:0] spi_rd = 16'h0000;
  logic [15:0] inj_rd = 16'h0000;
  logic        wrt, init_done, vld;
  logic [15:0] cmd, ptch_rt, roll_rt, yaw_rt;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int wrt_cnt = 0;
  int done_cnt = 0;
  int vld_cnt = 0;
  int last_done_cyc = -1;

  logic [15:0] exp_cmd_q[$];
  logic [47:0] exp_rate_q[$];
  logic [7:0]  byte_q[$];

  inert_sched #(.POR_CYCLES(POR)) dut (
    .clk       (clk),
    .rst       (rst),
    .INT       (int_in),
    .done      (spi_done | inj_done),
    .rd_data   (inj_done ? inj_rd : spi_rd),
    .wrt       (wrt),
    .cmd       (cmd),
    .init_done (init_done),
    .ptch_rt   (ptch_rt),
    .roll_rt   (roll_rt),
    .yaw_rt    (yaw_rt),
    .vld       (vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI monarch model: checks each command against the scoreboard, answers done 10 cycles later.
  initial begin : spi_model
    logic [15:0] cap;
    logic [15:0] e_cmd;
    logic [7:0]  b;
    bit          abort;
    forever begin
      @(negedge clk);
      if (wrt === 1'b1) begin
        wrt_cnt++;
        cap = cmd;
        n_checks++;
        if (exp_cmd_q.size() == 0) begin
          n_fail++;
          $display("FAIL cmd_seq: unexpected wrt with cmd=%h, no command expected", cmd);
        end else begin
          e_cmd = exp_cmd_q.pop_front();
          if (cmd !== e_cmd) begin
            n_fail++;
            $display("FAIL cmd_seq: cmd=%h expected %h", cmd, e_cmd);
          end
        end
        abort = 1'b0;
        for (int i = 0; i < 9; i++) begin
          @(negedge clk);
          if (rst) abort = 1'b1;
        end
        if (!abort) begin
          n_checks++;
          if (cmd !== cap) begin
            n_fail++;
            $display("FAIL cmd_hold: cmd=%h at done, was %h at wrt", cmd, cap);
          end
          b = 8'h00;
          if (byte_q.size() != 0) b = byte_q.pop_front();
          spi_rd = {8'hC3, b};
          spi_done = 1'b1;
          done_cnt++;
          last_done_cyc = cyc;
          @(negedge clk);
          spi_done = 1'b0;
        end
      end
    end
  end

  initial begin : vld_mon
    logic [47:0] e_rate;
    forever begin
      @(negedge clk);
      if (vld === 1'b1) begin
        vld_cnt++;
        n_checks++;
        if (exp_rate_q.size() == 0) begin
          n_fail++;
          $display("FAIL vld_unexpected: vld with rates %h %h %h, none expected", ptch_rt, roll_rt, yaw_rt);
        end else begin
          e_rate = exp_rate_q.pop_front();
          if ({ptch_rt, roll_rt, yaw_rt} !== e_rate) begin
            n_fail++;
            $display("FAIL rate_words: got %h %h %h expected %h %h %h", ptch_rt, roll_rt, yaw_rt,
                     e_rate[47:32], e_rate[31:16], e_rate[15:0]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic push_read(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    byte_q.push_back(b0); byte_q.push_back(b1); byte_q.push_back(b2);
    byte_q.push_back(b3); byte_q.push_back(b4); byte_q.push_back(b5);
    for (int i = 0; i < 6; i++) exp_cmd_q.push_back({8'(8'hA2 + i), 8'h00});
    exp_rate_q.push_back({b1, b0, b3, b2, b5, b4});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    int_in = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (wrt !== 1'b0) begin n_fail++; $display("FAIL reset_wrt: %b expected 0", wrt); end
    n_checks++; if (cmd !== 16'h0000) begin n_fail++; $display("FAIL reset_cmd: %h expected 0000", cmd); end
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: %b expected 0", init_done); end
    n_checks++; if (vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: %b expected 0", vld); end
    n_checks++;
    if ({ptch_rt, roll_rt, yaw_rt} !== 48'h0) begin
      n_fail++; $display("FAIL reset_rates: %h %h %h expected 0", ptch_rt, roll_rt, yaw_rt);
    end
  endtask

  // Releases reset with INT held high and checks POR timing and the config sequence.
  task automatic test_por_cfg();
    int rel, wbase, dbase;
    bit seen;
    exp_cmd_q.push_back(16'h0D02);
    exp_cmd_q.push_back(16'h1160);
    exp_cmd_q.push_back(16'h1440);
    int_in = 1'b1;
    wbase = wrt_cnt;
    dbase = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (wrt === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || (cyc - rel) != 9) begin
      n_fail++; $display("FAIL por_first_wrt: seen=%0d after %0d cycles, expected 9", seen, cyc - rel);
    end
    int_in = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (init_done === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || (cyc - last_done_cyc) != 1 || (done_cnt - dbase) != 3) begin
      n_fail++;
      $display("FAIL init_done_rise: seen=%0d, %0d cycles after done #%0d, expected 1 cycle after done #3",
               seen, cyc - last_done_cyc, done_cnt - dbase);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if ((wrt_cnt - wbase) != 3 || exp_cmd_q.size() != 0) begin
      n_fail++; $display("FAIL cfg_count: %0d writes, %0d commands pending, expected 3 and 0",
                         wrt_cnt - wbase, exp_cmd_q.size());
    end
  endtask

  task automatic test_single_read();
    int t0, vbase, wbase;
    bit seen;
    push_read(8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A);
    vbase = vld_cnt;
    wbase = wrt_cnt;
    @(negedge clk);
    int_in = 1'b1;
    t0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (wrt === 1'b1) seen = 1'b1;
    end
    int_in = 1'b0;
    n_checks++;
    if (!seen || (cyc - t0) != 4) begin
      n_fail++; $display("FAIL int_to_wrt: seen=%0d latency %0d, expected 4", seen, cyc - t0);
    end
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (vld === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || (cyc - last_done_cyc) != 2) begin
      n_fail++; $display("FAIL done_to_vld: seen=%0d latency %0d, expected 2", seen, cyc - last_done_cyc);
    end
    repeat (30) @(negedge clk);
    n_checks++;
    if ((vld_cnt - vbase) != 1 || (wrt_cnt - wbase) != 6) begin
      n_fail++; $display("FAIL single_read_count: %0d vld %0d wrt, expected 1 and 6", vld_cnt - vbase, wrt_cnt - wbase);
    end
  endtask

  task automatic test_stale_int();
    int nw, nv, v1, restart, unstable, vbase, wbase;
    logic [47:0] first_rate;
    push_read(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
    push_read(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
    vbase = vld_cnt;
    wbase = wrt_cnt;
    nw = 0; nv = 0; v1 = 0; restart = -1; unstable = 0;
    first_rate = '0;
    @(negedge clk);
    int_in = 1'b1;
    for (int i = 0; i < 600 && nv < 2; i++) begin
      @(negedge clk);
      if (wrt === 1'b1) nw++;
      if (nw == 12) int_in = 1'b0;
      if (vld === 1'b1) begin
        nv++;
        if (nv == 1) begin
          v1 = cyc;
          first_rate = {ptch_rt, roll_rt, yaw_rt};
        end
      end else if (nv == 1) begin
        if ({ptch_rt, roll_rt, yaw_rt} !== first_rate) unstable++;
        if (wrt === 1'b1 && restart < 0) restart = cyc - v1;
      end
    end
    int_in = 1'b0;
    n_checks++;
    if (nv != 2 || restart != 2) begin
      n_fail++; $display("FAIL stale_restart: %0d vld seen, restart after %0d cycles, expected 2 and 2", nv, restart);
    end
    n_checks++;
    if (unstable != 0) begin
      n_fail++; $display("FAIL rate_hold: rate words changed on %0d cycles between pulses, expected 0", unstable);
    end
    repeat (40) @(negedge clk);
    n_checks++;
    if ((vld_cnt - vbase) != 2 || (wrt_cnt - wbase) != 12) begin
      n_fail++; $display("FAIL stale_count: %0d vld %0d wrt, expected 2 and 12", vld_cnt - vbase, wrt_cnt - wbase);
    end
  endtask

  task automatic test_spurious_done();
    int vbase, wbase;
    bit seen;
    vbase = vld_cnt;
    wbase = wrt_cnt;
    @(negedge clk);
    inj_rd = 16'h00EE;
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (wrt_cnt != wbase || vld_cnt != vbase) begin
      n_fail++; $display("FAIL idle_done: %0d wrt %0d vld after idle done, expected 0 and 0", wrt_cnt - wbase, vld_cnt - vbase);
    end
    push_read(8'h5A, 8'hA5, 8'hC3, 8'h3C, 8'h0F, 8'hF0);
    int_in = 1'b1;
    repeat (3) @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    int_in = 1'b0;
    n_checks++;
    if (wrt !== 1'b1 || cmd !== 16'hA200) begin
      n_fail++; $display("FAIL issue_done: wrt=%b cmd=%h, expected 1 and a200", wrt, cmd);
    end
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (vld === 1'b1) seen = 1'b1;
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (!seen || (vld_cnt - vbase) != 1 || (wrt_cnt - wbase) != 6) begin
      n_fail++; $display("FAIL spurious_count: %0d vld %0d wrt, expected 1 and 6", vld_cnt - vbase, wrt_cnt - wbase);
    end
  endtask

  task automatic test_reset_mid_read();
    int vbase, dbase;
    bit seen;
    byte_q.push_back(8'h21); byte_q.push_back(8'h43); byte_q.push_back(8'h65);
    byte_q.push_back(8'h87); byte_q.push_back(8'hA9); byte_q.push_back(8'hCB);
    exp_cmd_q.push_back(16'hA200);
    exp_cmd_q.push_back(16'hA300);
    exp_cmd_q.push_back(16'hA400);
    vbase = vld_cnt;
    dbase = done_cnt;
    @(negedge clk);
    int_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk);
      if ((done_cnt - dbase) >= 3) seen = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    int_in = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!seen || wrt !== 1'b0 || cmd !== 16'h0000 || init_done !== 1'b0 || vld !== 1'b0 ||
        {ptch_rt, roll_rt, yaw_rt} !== 48'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: seen=%0d wrt=%b cmd=%h init=%b vld=%b rates=%h %h %h, expected all 0",
               seen, wrt, cmd, init_done, vld, ptch_rt, roll_rt, yaw_rt);
    end
    n_checks++;
    if (exp_cmd_q.size() != 0) begin
      n_fail++; $display("FAIL mid_reset_cmds: %0d read commands not issued, expected 0", exp_cmd_q.size());
    end
    byte_q.delete();
    test_por_cfg();
    n_checks++;
    if (vld_cnt != vbase) begin
      n_fail++; $display("FAIL mid_reset_vld: %0d vld pulses, expected 0", vld_cnt - vbase);
    end
  endtask

  task automatic test_negative();
    bit seen;
    push_read(8'h00, 8'h80, 8'hFF, 8'hFF, 8'h01, 8'h00);
    @(negedge clk);
    int_in = 1'b1;
    repeat (4) @(negedge clk);
    int_in = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (vld === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || $signed(ptch_rt) != -16'sd32768 || $signed(roll_rt) != -16'sd1 || $signed(yaw_rt) != 16'sd1) begin
      n_fail++; $display("FAIL signed_rates: seen=%0d ptch=%0d roll=%0d yaw=%0d, expected -32768 -1 1",
                         seen, $signed(ptch_rt), $signed(roll_rt), $signed(yaw_rt));
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_por_cfg();
    test_single_read();
    test_stale_int();
    test_spurious_done();
    test_reset_mid_read();
    test_negative();
    n_checks++;
    if (exp_cmd_q.size() != 0 || exp_rate_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d commands %0d rate sets outstanding, expected 0 and 0",
                         exp_cmd_q.size(), exp_rate_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
